// File: rtl/mem_line_ctrl_if.sv
// mem_line_ctrl_if: bundle of the L2-side and memory-bus-side signals of the
// line controller.
//   L2 side  : read/write requests, index/tags, victim data, fill data, ready pulse
//   Mem side : command channel (valid/ready/we/addr), write beats (valid/ready/data),
//              read beats (valid/data, always accepted), sticky protocol error flag
// Modports: slave  = the controller's view
//           master = the environment's view (L2 plus memory)
interface mem_line_ctrl_if #(
    parameter int unsigned BEAT_W = 64
);
    // L2 side
    logic          read_L2_MEM;
    logic          write_L2_MEM;
    logic [7:0]    index_L2_MEM;
    logic [17:0]   tag_L2_MEM;
    logic [17:0]   write_tag_L2_MEM;
    logic [511:0]  write_data_L2_MEM;
    logic [511:0]  read_data_MEM_L2;
    logic          ready_MEM_L2;
    // Memory bus side
    logic              mem_cmd_valid;
    logic              mem_cmd_ready;
    logic              mem_cmd_we;
    logic [25:0]       mem_cmd_addr;
    logic              mem_wvalid;
    logic              mem_wready;
    logic [BEAT_W-1:0] mem_wdata;
    logic              mem_rvalid;
    logic [BEAT_W-1:0] mem_rdata;
    logic              protocol_err;

    modport slave (
        input  read_L2_MEM, write_L2_MEM, index_L2_MEM, tag_L2_MEM, write_tag_L2_MEM,
               write_data_L2_MEM, mem_cmd_ready, mem_wready, mem_rvalid, mem_rdata,
        output read_data_MEM_L2, ready_MEM_L2, mem_cmd_valid, mem_cmd_we, mem_cmd_addr,
               mem_wvalid, mem_wdata, protocol_err
    );

    modport master (
        output read_L2_MEM, write_L2_MEM, index_L2_MEM, tag_L2_MEM, write_tag_L2_MEM,
               write_data_L2_MEM, mem_cmd_ready, mem_wready, mem_rvalid, mem_rdata,
        input  read_data_MEM_L2, ready_MEM_L2, mem_cmd_valid, mem_cmd_we, mem_cmd_addr,
               mem_wvalid, mem_wdata, protocol_err
    );
endinterface

// File: rtl/mem_line_ctrl.sv
// mem_line_ctrl: converts whole-line L2 read / write-back requests into a command
// plus a fixed-length burst of BEAT_W-bit beats on the memory bus. A combined
// request is serialized write first, then read, with a single ready pulse at the end.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : mem_line_ctrl_if.slave (L2 request/response and memory bus signals)
// All outputs are registered.
module mem_line_ctrl #(
    parameter int unsigned BEAT_W = 64
) (
    input  logic                clk,
    input  logic                rst,
    mem_line_ctrl_if.slave      bus
);
    localparam int unsigned BEATS     = 512 / BEAT_W;
    localparam int unsigned CntW      = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned BeatShift = $clog2(BEAT_W);
    localparam logic [CntW-1:0] LastCnt = CntW'(BEATS - 1);

    typedef enum logic [2:0] {
        StIdle,
        StWrCmd,
        StWrData,
        StRdCmd,
        StRdData,
        StResp,
        StGap
    } state_e;

    state_e          r_state;
    logic [CntW-1:0] r_cnt;
    logic            r_wr_pend;
    logic            r_rd_pend;
    logic [25:0]     r_wr_addr;
    logic [25:0]     r_rd_addr;
    logic [511:0]    r_wbuf;
    logic [511:0]    r_read_data;
    logic            r_ready;
    logic            r_cmd_valid;
    logic            r_cmd_we;
    logic [25:0]     r_cmd_addr;
    logic            r_wvalid;
    logic [BEAT_W-1:0] r_wdata;
    logic            r_protocol_err;

    logic [CntW-1:0] w_cnt_inc;
    logic [8:0]      w_wr_off;
    logic [8:0]      w_rd_off;

    assign w_cnt_inc = r_cnt + CntW'(1);
    // The next write beat is preloaded into r_wdata when the current one is taken.
    assign w_wr_off  = 9'(w_cnt_inc) << BeatShift;
    assign w_rd_off  = 9'(r_cnt) << BeatShift;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= StIdle;
            r_cnt          <= '0;
            r_wr_pend      <= 1'b0;
            r_rd_pend      <= 1'b0;
            r_wr_addr      <= '0;
            r_rd_addr      <= '0;
            r_wbuf         <= '0;
            r_read_data    <= '0;
            r_ready        <= 1'b0;
            r_cmd_valid    <= 1'b0;
            r_cmd_we       <= 1'b0;
            r_cmd_addr     <= '0;
            r_wvalid       <= 1'b0;
            r_wdata        <= '0;
            r_protocol_err <= 1'b0;
        end else begin
            r_ready <= 1'b0;
            // Stray read beats are dropped but remembered.
            if (bus.mem_rvalid && (r_state != StRdData)) begin
                r_protocol_err <= 1'b1;
            end

            unique case (r_state)
                StIdle: begin
                    if (bus.read_L2_MEM || bus.write_L2_MEM) begin
                        r_wr_pend   <= bus.write_L2_MEM;
                        r_rd_pend   <= bus.read_L2_MEM;
                        r_wr_addr   <= {bus.write_tag_L2_MEM, bus.index_L2_MEM};
                        r_rd_addr   <= {bus.tag_L2_MEM, bus.index_L2_MEM};
                        r_wbuf      <= bus.write_data_L2_MEM;
                        r_cmd_valid <= 1'b1;
                        if (bus.write_L2_MEM) begin
                            r_cmd_we   <= 1'b1;
                            r_cmd_addr <= {bus.write_tag_L2_MEM, bus.index_L2_MEM};
                            r_state    <= StWrCmd;
                        end else begin
                            r_cmd_we   <= 1'b0;
                            r_cmd_addr <= {bus.tag_L2_MEM, bus.index_L2_MEM};
                            r_state    <= StRdCmd;
                        end
                    end
                end
                StWrCmd: begin
                    if (bus.mem_cmd_ready) begin
                        r_cmd_valid <= 1'b0;
                        r_cnt       <= '0;
                        r_wvalid    <= 1'b1;
                        r_wdata     <= r_wbuf[BEAT_W-1:0];
                        r_state     <= StWrData;
                    end
                end
                StWrData: begin
                    if (bus.mem_wready) begin
                        if (r_cnt == LastCnt) begin
                            r_wvalid <= 1'b0;
                            if (r_rd_pend) begin
                                r_cmd_valid <= 1'b1;
                                r_cmd_we    <= 1'b0;
                                r_cmd_addr  <= r_rd_addr;
                                r_state     <= StRdCmd;
                            end else begin
                                r_ready <= 1'b1;
                                r_state <= StResp;
                            end
                        end else begin
                            r_cnt   <= w_cnt_inc;
                            r_wdata <= r_wbuf[w_wr_off +: BEAT_W];
                        end
                    end
                end
                StRdCmd: begin
                    if (bus.mem_cmd_ready) begin
                        r_cmd_valid <= 1'b0;
                        r_cnt       <= '0;
                        r_state     <= StRdData;
                    end
                end
                StRdData: begin
                    if (bus.mem_rvalid) begin
                        r_read_data[w_rd_off +: BEAT_W] <= bus.mem_rdata;
                        if (r_cnt == LastCnt) begin
                            r_ready <= 1'b1;
                            r_state <= StResp;
                        end else begin
                            r_cnt <= w_cnt_inc;
                        end
                    end
                end
                StResp: begin
                    r_state <= StGap;
                end
                // Turnaround so the L2 request still held high is not re-accepted.
                StGap: begin
                    r_state <= StIdle;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign bus.read_data_MEM_L2 = r_read_data;
    assign bus.ready_MEM_L2     = r_ready;
    assign bus.mem_cmd_valid    = r_cmd_valid;
    assign bus.mem_cmd_we       = r_cmd_we;
    assign bus.mem_cmd_addr     = r_cmd_addr;
    assign bus.mem_wvalid       = r_wvalid;
    assign bus.mem_wdata        = r_wdata;
    assign bus.protocol_err     = r_protocol_err;
endmodule
